// File: rtl/mean_window_accum.sv
// Sliding-window mean over the last 2**LOG2_N accepted samples; 1 clk acc->out_valid, in_ready = ~out_valid | out_ready.
// Optional feature: `define MEAN_ROUND_EN for round-half-up means (default build truncates).
module mean_window_accum #(
  parameter int DW     = 8,
  parameter int LOG2_N = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DW-1:0]     in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DW-1:0]     out_data,
  output logic              warm,
  output logic [LOG2_N:0]   fill_cnt
);

  localparam int N  = 1 << LOG2_N;
  localparam int SW = DW + LOG2_N;

  typedef enum logic {FILL, RUN} state_t;

  state_t            state_q;
  logic [SW-1:0]     sum_q, sum_d;
  logic [LOG2_N-1:0] wr_ptr_q;
  logic [LOG2_N:0]   fill_q, fill_d;
  logic              out_valid_q, warm_q;
  logic [DW-1:0]     out_data_q;
  logic [DW-1:0]     win_q [N];
  logic              acc;
  logic [DW-1:0]     old_dat, mean_d;

  assign in_ready = ~out_valid_q | out_ready;
  assign acc      = in_valid & in_ready;

  // During FILL the slot under wr_ptr has never been summed, so nothing leaves the window.
  assign old_dat = (state_q == RUN) ? win_q[wr_ptr_q] : '0;
  assign sum_d   = sum_q + SW'(in_data) - SW'(old_dat);
  assign fill_d  = fill_q + (LOG2_N+1)'(1);

`ifdef MEAN_ROUND_EN
  logic [SW-1:0] rnd_sum;
  assign rnd_sum = sum_d + SW'(N / 2);
  assign mean_d  = DW'(rnd_sum >> LOG2_N);
`else
  assign mean_d  = DW'(sum_d >> LOG2_N);
`endif

  always_ff @(posedge clk) begin
    if (acc && !clear) win_q[wr_ptr_q] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FILL;
      sum_q       <= '0;
      wr_ptr_q    <= '0;
      fill_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      warm_q      <= 1'b0;
    end else if (clear) begin
      state_q     <= FILL;
      sum_q       <= '0;
      wr_ptr_q    <= '0;
      fill_q      <= '0;
      out_valid_q <= 1'b0;
      warm_q      <= 1'b0;
    end else begin
      if (out_ready) out_valid_q <= 1'b0;
      if (acc) begin
        sum_q    <= sum_d;
        wr_ptr_q <= wr_ptr_q + LOG2_N'(1);
        case (state_q)
          FILL: begin
            fill_q <= fill_d;
            if (fill_d == (LOG2_N+1)'(N)) begin
              state_q     <= RUN;
              warm_q      <= 1'b1;
              out_valid_q <= 1'b1;
              out_data_q  <= mean_d;
            end
          end
          RUN: begin
            out_valid_q <= 1'b1;
            out_data_q  <= mean_d;
          end
          default: state_q <= FILL;
        endcase
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign warm      = warm_q;
  assign fill_cnt  = fill_q;

endmodule

// File: tb/tb_mean_window_accum.sv
// Directed bench for mean_window_accum (DW=8, N=8); expected means follow the build's rounding mode.
module tb_mean_window_accum;

  logic       clk = 1'b0;
  logic       rst_n, clear, in_valid, in_ready, out_valid, out_ready, warm;
  logic [7:0] in_data, out_data;
  logic [3:0] fill_cnt;

  int errors = 0;
  int checks = 0;

`ifdef MEAN_ROUND_EN
  localparam int RND = 4;
`else
  localparam int RND = 0;
`endif

  mean_window_accum #(.DW(8), .LOG2_N(3)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .warm(warm), .fill_cnt(fill_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] exp_mean(input int sum);
    exp_mean = 8'((sum + RND) >> 3);
  endfunction

  // Offer one sample and wait (bounded) for it to be accepted; returns 1 clk after the accept.
  task automatic push(input logic [7:0] d);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL push_timeout: in_ready=%0b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %0h want 0", out_data); end
    checks++; if (warm !== 1'b0) begin errors++; $display("FAIL reset_warm: got %0b want 0", warm); end
    checks++; if (fill_cnt !== 4'd0) begin errors++; $display("FAIL reset_fill_cnt: got %0d want 0", fill_cnt); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 7; i++) begin
      push(8'h10);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fill_no_output[%0d]: got %0b want 0", i, out_valid); end
      checks++; if (fill_cnt !== 4'(i)) begin errors++; $display("FAIL fill_cnt[%0d]: got %0d want %0d", i, fill_cnt, i); end
    end
    push(8'h10);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL fill_first_valid: got %0b want 1", out_valid); end
    checks++; if (out_data !== 8'h10) begin errors++; $display("FAIL fill_first_mean: got %0h want 10", out_data); end
    checks++; if (warm !== 1'b1) begin errors++; $display("FAIL fill_warm: got %0b want 1", warm); end
    checks++; if (fill_cnt !== 4'd8) begin errors++; $display("FAIL fill_full_cnt: got %0d want 8", fill_cnt); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fill_drain: got %0b want 0", out_valid); end
  endtask

  task automatic test_wrap();
    do_clear();
    for (int i = 0; i < 8; i++) push(8'(i));
    checks++; if (out_data !== exp_mean(28)) begin errors++; $display("FAIL wrap_mean0_7: got %0h want %0h", out_data, exp_mean(28)); end
    push(8'd8);
    checks++; if (out_data !== exp_mean(36)) begin errors++; $display("FAIL wrap_mean1_8: got %0h want %0h", out_data, exp_mean(36)); end
  endtask

  task automatic test_backpressure();
    @(posedge clk); #1;
    out_ready = 1'b0;
    push(8'd9);
    checks++; if (out_data !== exp_mean(44)) begin errors++; $display("FAIL bp_mean9: got %0h want %0h", out_data, exp_mean(44)); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %0b want 0", in_ready); end
    in_valid = 1'b1; in_data = 8'd10;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++; if (out_data !== exp_mean(44)) begin errors++; $display("FAIL bp_hold[%0d]: got %0h want %0h", i, out_data, exp_mean(44)); end
      checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_stall[%0d]: in_ready=%0b out_valid=%0b want 0/1", i, in_ready, out_valid); end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (out_data !== exp_mean(52) || out_valid !== 1'b1) begin errors++; $display("FAIL bp_release: data=%0h valid=%0b want %0h/1", out_data, out_valid, exp_mean(52)); end
    push(8'd11);
    checks++; if (out_data !== exp_mean(60)) begin errors++; $display("FAIL bp_after: got %0h want %0h", out_data, exp_mean(60)); end
  endtask

  task automatic test_small_sum();
    do_clear();
    for (int i = 0; i < 8; i++) push(i < 4 ? 8'h01 : 8'h00);
    checks++; if (out_data !== exp_mean(4) || out_valid !== 1'b1) begin errors++; $display("FAIL small_sum: data=%0h valid=%0b want %0h/1", out_data, out_valid, exp_mean(4)); end
  endtask

  task automatic test_clear();
    do_clear();
    for (int i = 0; i < 5; i++) push(8'h20);
    checks++; if (fill_cnt !== 4'd5) begin errors++; $display("FAIL clear_pre_cnt: got %0d want 5", fill_cnt); end
    clear = 1'b1; in_valid = 1'b1; in_data = 8'h99;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL clear_in_ready: got %0b want 1", in_ready); end
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    checks++; if (fill_cnt !== 4'd0 || out_valid !== 1'b0 || warm !== 1'b0) begin errors++; $display("FAIL clear_state: cnt=%0d valid=%0b warm=%0b want 0/0/0", fill_cnt, out_valid, warm); end
    checks++; if (out_data !== exp_mean(4)) begin errors++; $display("FAIL clear_hold_data: got %0h want %0h", out_data, exp_mean(4)); end
    for (int i = 0; i < 7; i++) push(8'hFF);
    checks++; if (out_valid !== 1'b0 || fill_cnt !== 4'd7) begin errors++; $display("FAIL clear_refill7: valid=%0b cnt=%0d want 0/7", out_valid, fill_cnt); end
    push(8'hFF);
    checks++; if (out_data !== 8'hFF || out_valid !== 1'b1) begin errors++; $display("FAIL clear_ff_mean: data=%0h valid=%0b want ff/1", out_data, out_valid); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_data !== 8'h00 || warm !== 1'b0 || fill_cnt !== 4'd0) begin
      errors++; $display("FAIL async_reset: valid=%0b data=%0h warm=%0b cnt=%0d want 0/0/0/0", out_valid, out_data, warm, fill_cnt);
    end
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 7; i++) push(8'h40);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL async_refill7: got %0b want 0", out_valid); end
    push(8'h40);
    checks++; if (out_data !== 8'h40 || out_valid !== 1'b1) begin errors++; $display("FAIL async_refill_mean: data=%0h valid=%0b want 40/1", out_data, out_valid); end
  endtask

  task automatic test_back_to_back();
    int s;
    s = 8 * 8'h40;
    for (int i = 0; i < 4; i++) begin
      push(8'h50);
      s = s - 8'h40 + 8'h50;
      checks++; if (out_data !== exp_mean(s) || out_valid !== 1'b1) begin errors++; $display("FAIL b2b[%0d]: data=%0h valid=%0b want %0h/1", i, out_data, out_valid, exp_mean(s)); end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_wrap();
    test_backpressure();
    test_small_sum();
    test_clear();
    test_async_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
